// File: rtl/btn_evt_pkg.sv
// Shared event codes and I/O address for the button event queue.
package btn_evt_pkg;

   localparam logic [31:0] EVT_NONE    = 32'd0;
   localparam logic [31:0] EVT_UP      = 32'd1;
   localparam logic [31:0] EVT_DOWN    = 32'd2;
   localparam logic [31:0] IO_BTN_ADDR = 32'd4096;

endpackage

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser, debounce counter, stable level and a
// registered one-cycle pulse on each accepted press (stable 0->1).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          press_q, press_d;

   // Counter only runs while the synchronised level disagrees with stable.
   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync_q[1];
            press_d  = sync_q[1];
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_i};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         press_q  <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/button_event_queue.sv
// Debounced BTNU/BTND press events queued for the processor; one event is
// popped per rising edge of rd_en.
module button_event_queue
   import btn_evt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          btn_up,
   input  logic                          btn_down,
   input  logic                          rd_en,
   output logic [31:0]                   rd_data,
   output logic                          pending,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   logic          push_up, push_dn;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, dn_slot;
   logic [PW:0]   count_q, count_d, free;
   logic          rd_en_q, ovf_q, ovf_d;
   logic          pop, wr_up, wr_dn;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clock   (clock),
      .reset   (reset),
      .btn_i   (btn_up),
      .press_o (push_up)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
      .clock   (clock),
      .reset   (reset),
      .btn_i   (btn_down),
      .press_o (push_dn)
   );

   // Pop frees its slot before pushes are admitted; UP has priority over DOWN.
   always_comb begin
      pop     = rd_en && !rd_en_q && (count_q != '0);
      free    = DEPTH_C - count_q + (PW+1)'(pop);
      wr_up   = push_up && (free != '0);
      wr_dn   = push_dn && (free > (PW+1)'(wr_up));
      dn_slot = tail_q + PW'(wr_up);
      tail_d  = tail_q + PW'(wr_up) + PW'(wr_dn);
      head_d  = head_q + PW'(pop);
      count_d = count_q - (PW+1)'(pop) + (PW+1)'(wr_up) + (PW+1)'(wr_dn);
      ovf_d   = ovf_q | (push_up & ~wr_up) | (push_dn & ~wr_dn);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= EVT_NONE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rd_en_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (wr_up) mem_q[tail_q]  <= EVT_UP;
         if (wr_dn) mem_q[dn_slot] <= EVT_DOWN;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rd_en_q <= rd_en;
         ovf_q   <= ovf_d;
      end
   end

   assign rd_data  = (count_q != '0) ? mem_q[head_q] : EVT_NONE;
   assign pending  = (count_q != '0);
   assign count    = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Bench for button_event_queue: directed scenarios plus random presses/reads,
// checked against a window-based debounce model and a queue-based FIFO model.
module tb_button_event_queue;

   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        btn_up = 1'b0;
   logic        btn_down = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic        pending;
   logic [2:0]  count;
   logic        overflow;

   int n_chk = 0;
   int n_fail = 0;

   button_event_queue #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .pending  (pending),
      .count    (count),
      .overflow (overflow)
   );

   initial forever #5 clock = ~clock;

   wire [36:0] obs = {rd_data, pending, count, overflow};

   // Reference model. A level is accepted once the last D synchronised
   // samples all disagree with the accepted level; sync sample n is the raw
   // pad value seen at edge n-2 (zero before that). An accepted press is
   // enqueued on the following edge.
   int       mq[$];
   bit       m_ovf, m_rdp;
   bit [2:0] m_raw[2];
   bit [D-1:0] m_syn[2];
   bit       m_stb[2], m_ev[2];

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_ovf = 0;
         m_rdp = 0;
         for (int b = 0; b < 2; b++) begin
            m_raw[b] = '0; m_syn[b] = '0; m_stb[b] = 0; m_ev[b] = 0;
         end
      end else begin
         if (rd_en && !m_rdp && mq.size() != 0) void'(mq.pop_front());
         m_rdp = rd_en;
         for (int b = 0; b < 2; b++) begin
            if (m_ev[b]) begin
               if (mq.size() < DEPTH) mq.push_back(b + 1);
               else m_ovf = 1;
               m_ev[b] = 0;
            end
         end
         for (int b = 0; b < 2; b++) begin
            m_raw[b] = {m_raw[b][1:0], (b == 0) ? btn_up : btn_down};
            m_syn[b] = {m_syn[b][D-2:0], m_raw[b][2]};
            if (m_syn[b] == {D{~m_stb[b]}}) begin
               m_stb[b] = ~m_stb[b];
               m_ev[b]  = m_stb[b];
            end
         end
      end
   end

   function automatic logic [36:0] mdl();
      logic [31:0] h;
      h = (mq.size() != 0) ? 32'(mq[0]) : 32'd0;
      return {h, mq.size() != 0, 3'(mq.size()), m_ovf};
   endfunction

   task automatic test_reset();
      reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; rd_en = 1'b0;
      #1;
      n_chk++;
      if (obs !== 37'd0) begin
         n_fail++; $display("FAIL reset_async: got %h want 0", obs);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_chk++;
      if (obs !== mdl()) begin
         n_fail++; $display("FAIL reset_hold: got %h want %h", obs, mdl());
      end
      reset = 1'b1;
   endtask

   task automatic test_clean_up();
      btn_up = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock);
         n_chk++;
         if (pending !== (k == 7) || obs !== mdl()) begin
            n_fail++; $display("FAIL clean_latency edge %0d: got %h want pending=%0d model %h", k, obs, (k == 7), mdl());
         end
      end
      btn_up = 1'b0;
      repeat (10) begin
         @(negedge clock); n_chk++;
         if (obs !== mdl()) begin n_fail++; $display("FAIL clean_release: got %h want %h", obs, mdl()); end
      end
      rd_en = 1'b1;
      #1; n_chk++;
      if (rd_data !== 32'd1) begin n_fail++; $display("FAIL clean_read_head: got %0d want 1", rd_data); end
      @(negedge clock);
      rd_en = 1'b0;
      n_chk++;
      if (rd_data !== 32'd0 || pending !== 1'b0) begin
         n_fail++; $display("FAIL clean_read_after: rd_data=%0d pending=%0d want 0 0", rd_data, pending);
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 20; i++) begin
         btn_down = ((i / 2) % 2 == 0);
         @(negedge clock); n_chk++;
         if (obs !== mdl()) begin n_fail++; $display("FAIL bounce_toggle: got %h want %h", obs, mdl()); end
      end
      btn_down = 1'b0;
      repeat (10) @(negedge clock);
      n_chk++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL bounce_none: count=%0d want 0", count); end
      btn_down = 1'b1;
      repeat (10) @(negedge clock);
      n_chk++;
      if (count !== 3'd1 || rd_data !== 32'd2) begin
         n_fail++; $display("FAIL bounce_one: count=%0d rd_data=%0d want 1 2", count, rd_data);
      end
      btn_down = 1'b0;
      repeat (10) @(negedge clock);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      n_chk++;
      if (obs !== mdl() || count !== 3'd0) begin n_fail++; $display("FAIL bounce_drain: got %h want %h", obs, mdl()); end
   endtask

   task automatic test_simultaneous();
      int exp_r[3] = '{1, 2, 0};
      btn_up = 1'b1; btn_down = 1'b1;
      repeat (10) @(negedge clock);
      n_chk++;
      if (count !== 3'd2 || obs !== mdl()) begin
         n_fail++; $display("FAIL simul_count: count=%0d want 2 (model %h)", count, mdl());
      end
      btn_up = 1'b0; btn_down = 1'b0;
      repeat (10) @(negedge clock);
      for (int r = 0; r < 3; r++) begin
         rd_en = 1'b1;
         #1; n_chk++;
         if (rd_data !== 32'(exp_r[r])) begin
            n_fail++; $display("FAIL simul_read%0d: got %0d want %0d", r, rd_data, exp_r[r]);
         end
         @(negedge clock);
         rd_en = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic test_overflow();
      repeat (5) begin
         btn_up = 1'b1;
         repeat (8) begin
            @(negedge clock); n_chk++;
            if (obs !== mdl()) begin n_fail++; $display("FAIL ovf_press: got %h want %h", obs, mdl()); end
         end
         btn_up = 1'b0;
         repeat (8) @(negedge clock);
      end
      n_chk++;
      if (count !== 3'd4 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_full: count=%0d overflow=%0d want 4 1", count, overflow);
      end
      for (int r = 0; r < 4; r++) begin
         rd_en = 1'b1;
         #1; n_chk++;
         if (rd_data !== 32'd1) begin n_fail++; $display("FAIL ovf_read%0d: got %0d want 1", r, rd_data); end
         @(negedge clock);
         rd_en = 1'b0;
         @(negedge clock);
      end
      n_chk++;
      if (overflow !== 1'b1 || count !== 3'd0) begin
         n_fail++; $display("FAIL ovf_sticky: overflow=%0d count=%0d want 1 0", overflow, count);
      end
   endtask

   task automatic test_held_read();
      repeat (3) begin
         btn_up = 1'b1; repeat (8) @(negedge clock);
         btn_up = 1'b0; repeat (8) @(negedge clock);
      end
      rd_en = 1'b1;
      repeat (10) @(negedge clock);
      rd_en = 1'b0;
      @(negedge clock);
      n_chk++;
      if (count !== 3'd2 || obs !== mdl()) begin
         n_fail++; $display("FAIL held_read: count=%0d want 2 (got %h model %h)", count, obs, mdl());
      end
      repeat (2) begin
         btn_up = 1'b1; repeat (8) @(negedge clock);
         btn_up = 1'b0; repeat (8) @(negedge clock);
      end
      n_chk++;
      if (count !== 3'd4) begin n_fail++; $display("FAIL held_fill: count=%0d want 4", count); end
      // Line the rd_en rise up with the edge that writes this press.
      btn_up = 1'b1;
      repeat (6) @(negedge clock);
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      n_chk++;
      if (count !== 3'd4 || overflow !== 1'b0 || obs !== mdl()) begin
         n_fail++; $display("FAIL full_pop_push: count=%0d overflow=%0d want 4 0", count, overflow);
      end
      btn_up = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   task automatic test_reset_mid();
      repeat (2) begin
         btn_up = 1'b1; repeat (8) @(negedge clock);
         btn_up = 1'b0; repeat (8) @(negedge clock);
      end
      n_chk++;
      if (count !== 3'd2) begin n_fail++; $display("FAIL rmid_queued: count=%0d want 2", count); end
      btn_up = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      #1; n_chk++;
      if (obs !== 37'd0) begin n_fail++; $display("FAIL rmid_clear: got %h want 0", obs); end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clock); n_chk++;
         if (pending !== (k == 7) || obs !== mdl()) begin
            n_fail++; $display("FAIL rmid_repress edge %0d: got %h want pending=%0d", k, obs, (k == 7));
         end
      end
      btn_up = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock); n_chk++;
         if (obs !== mdl()) begin
            n_fail++; $display("FAIL random cycle %0d: got %h want %h", i, obs, mdl());
         end
         if ($urandom_range(0, 11) == 0) btn_up = ~btn_up;
         if ($urandom_range(0, 11) == 0) btn_down = ~btn_down;
         rd_en = ($urandom_range(0, 5) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_clean_up();
      test_bounce();
      test_simultaneous();
      test_overflow();
      test_reset();
      test_held_read();
      test_reset();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
